// File: rtl/bsg_bitwise_op_pkg.sv
// bsg_bitwise_op_pkg: op/state encodings and the per-bit op function shared by issue and fold logic
package bsg_bitwise_op_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_XNOR   = 3'd3,
        OP_NAND   = 3'd4,
        OP_NOR    = 3'd5,
        OP_ANDN   = 3'd6,
        OP_PASS_A = 3'd7
    } bsg_bitwise_op_e;

    typedef enum logic {IDLE, ACCUM} state_e;

    // Every op is bitwise, so one bit slice is applied across the whole word.
    function automatic logic op(input logic a, input logic b, input bsg_bitwise_op_e sel);
        case (sel)
            OP_AND:  op = a & b;
            OP_OR:   op = a | b;
            OP_XOR:  op = a ^ b;
            OP_XNOR: op = ~(a ^ b);
            OP_NAND: op = ~(a & b);
            OP_NOR:  op = ~(a | b);
            OP_ANDN: op = a & ~b;
            default: op = a;
        endcase
    endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// bsg_two_fifo: two-entry registered FIFO; ready_o and v_o come from the occupancy register only
module bsg_two_fifo #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem [2];
    logic               rptr, wptr;
    logic [1:0]         count;

    assign ready_o = count != 2'd2;
    assign v_o     = count != 2'd0;
    assign data_o  = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rptr   <= 1'b0;
            wptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (v_i) begin
                mem[wptr] <= data_i;
                wptr      <= ~wptr;
            end
            if (yumi_i)
                rptr <= ~rptr;
            count <= count + {1'b0, v_i} - {1'b0, yumi_i};
        end
    end

    always_ff @(posedge clk_i)
        if (!reset_i)
            assert (v_o || !yumi_i);

endmodule

// File: rtl/bsg_bitwise_op_pipe.sv
// bsg_bitwise_op_pipe: registered bitwise op unit with burst-accumulate and a two-entry output buffer
module bsg_bitwise_op_pipe
    import bsg_bitwise_op_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    input  logic [2:0]         op_i,
    input  logic               accum_i,
    input  logic               last_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               parity_o,
    output logic               zero_o,
    output logic               v_o,
    input  logic               yumi_i
);

    state_e             state;
    bsg_bitwise_op_e    op_q;
    logic [width_p-1:0] acc, r, inner, fold, enq_data;
    logic               accept, idle, enq;

    always_comb begin
        r     = '0;
        inner = '0;
        fold  = '0;
        for (int i = 0; i < width_p; i++) begin
            r[i]     = op(a_i[i], b_i[i], bsg_bitwise_op_e'(op_i));
            inner[i] = op(a_i[i], b_i[i], op_q);
            fold[i]  = op(acc[i], inner[i], op_q);
        end
    end

    assign accept   = valid_i & ready_o;
    assign idle     = state == IDLE;
    assign enq      = accept & (idle ? (~accum_i | last_i) : last_i);
    assign enq_data = idle ? r : fold;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            acc   <= '0;
            op_q  <= OP_AND;
        end else if (accept) begin
            if (idle) begin
                if (accum_i && !last_i) begin
                    acc   <= r;
                    op_q  <= bsg_bitwise_op_e'(op_i);
                    state <= ACCUM;
                end
            end else begin
                acc <= fold;
                if (last_i)
                    state <= IDLE;
            end
        end
    end

    bsg_two_fifo #(.width_p(width_p)) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (ready_o),
        .data_i  (enq_data),
        .v_i     (enq),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    assign parity_o = ^data_o;
    assign zero_o   = ~|data_o;

endmodule

// File: tb/tb_bsg_bitwise_op_pipe.sv
// tb_bsg_bitwise_op_pipe: directed vectors with hand-computed expectations for bsg_bitwise_op_pipe
module tb_bsg_bitwise_op_pipe;

    logic        clk = 1'b0;
    logic        reset_i, accum_i, last_i, valid_i, yumi_i;
    logic [15:0] a_i, b_i;
    logic [2:0]  op_i;
    logic        ready_o, parity_o, zero_o, v_o;
    logic [15:0] data_o;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] op_exp [8];

    always #5 clk = ~clk;

    bsg_bitwise_op_pipe #(.width_p(16)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .op_i     (op_i),
        .accum_i  (accum_i),
        .last_i   (last_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .parity_o (parity_o),
        .zero_o   (zero_o),
        .v_o      (v_o),
        .yumi_i   (yumi_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop();
        valid_i = 1'b0;
        yumi_i  = 1'b1;
        step();
        yumi_i  = 1'b0;
    endtask

    initial begin
        op_exp = '{16'h000F, 16'h0FFF, 16'h0FF0, 16'hF00F, 16'hFFF0, 16'hF000, 16'h00F0, 16'h00FF};
        reset_i = 1'b1; valid_i = 1'b1; yumi_i = 1'b0;
        a_i = 16'h00FF; b_i = 16'h0F0F; op_i = 3'd3; accum_i = 1'b0; last_i = 1'b0;
        step();
        step();
        chk("reset_v", {15'b0, v_o}, 16'd0);
        chk("reset_ready", {15'b0, ready_o}, 16'd1);

        // first beat after reset release: XNOR
        reset_i = 1'b0;
        step();
        chk("xnor_v", {15'b0, v_o}, 16'd1);
        chk("xnor_data", data_o, 16'hF00F);
        chk("xnor_parity", {15'b0, parity_o}, 16'd0);
        chk("xnor_zero", {15'b0, zero_o}, 16'd0);
        pop();
        chk("xnor_drained", {15'b0, v_o}, 16'd0);

        for (int k = 0; k < 8; k++) begin
            op_i = 3'(k); valid_i = 1'b1;
            step();
            chk($sformatf("op%0d_data", k), data_o, op_exp[k]);
            pop();
        end

        // backpressure: PASS_A 1,2,3 with no consumer
        op_i = 3'd7; b_i = 16'h0000; valid_i = 1'b1;
        a_i = 16'h0001; step();
        chk("bp_ready1", {15'b0, ready_o}, 16'd1);
        a_i = 16'h0002; step();
        chk("bp_ready_full", {15'b0, ready_o}, 16'd0);
        a_i = 16'h0003; step();
        chk("bp_held_ready", {15'b0, ready_o}, 16'd0);
        chk("bp_head1", data_o, 16'h0001);
        yumi_i = 1'b1; step();
        chk("bp_head2", data_o, 16'h0002);
        chk("bp_ready_again", {15'b0, ready_o}, 16'd1);
        step();
        chk("bp_head3", data_o, 16'h0003);
        pop();
        chk("bp_empty", {15'b0, v_o}, 16'd0);

        // accumulate AND, op_i changed on the last beat
        valid_i = 1'b1; op_i = 3'd0; accum_i = 1'b1; last_i = 1'b0;
        a_i = 16'hFFFF; b_i = 16'hF0F0; step();
        chk("acc_and_mid_v", {15'b0, v_o}, 16'd0);
        op_i = 3'd2; accum_i = 1'b0; last_i = 1'b1;
        a_i = 16'hFF00; b_i = 16'hFFFF; step();
        chk("acc_and_v", {15'b0, v_o}, 16'd1);
        chk("acc_and_data", data_o, 16'hF000);
        pop();
        chk("acc_and_single", {15'b0, v_o}, 16'd0);

        // accumulate XOR over three beats
        valid_i = 1'b1; op_i = 3'd2; accum_i = 1'b1; last_i = 1'b0;
        a_i = 16'h0001; b_i = 16'h0002; step();
        accum_i = 1'b0;
        a_i = 16'h0004; b_i = 16'h0008; step();
        chk("acc_xor_mid_v", {15'b0, v_o}, 16'd0);
        last_i = 1'b1;
        a_i = 16'h0010; b_i = 16'h0020; step();
        chk("acc_xor_data", data_o, 16'h003F);
        chk("acc_xor_parity", {15'b0, parity_o}, 16'd0);
        pop();

        // reset in the middle of a burst discards it
        valid_i = 1'b1; op_i = 3'd2; accum_i = 1'b1; last_i = 1'b0;
        a_i = 16'h0001; b_i = 16'h0002; step();
        valid_i = 1'b0; reset_i = 1'b1; step();
        reset_i = 1'b0; step();
        chk("midrst_v", {15'b0, v_o}, 16'd0);
        valid_i = 1'b1; accum_i = 1'b0; last_i = 1'b0;
        a_i = 16'h1234; b_i = 16'h1234; step();
        chk("midrst_next_v", {15'b0, v_o}, 16'd1);
        chk("midrst_next_data", data_o, 16'h0000);
        chk("midrst_next_zero", {15'b0, zero_o}, 16'd1);
        pop();

        // steady streaming, one in and one out per cycle
        valid_i = 1'b1; op_i = 3'd7; b_i = 16'hFFFF; a_i = 16'h0100; step();
        yumi_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a_i = 16'(i);
            step();
            chk($sformatf("stream%0d_data", i), data_o, 16'(i));
            chk($sformatf("stream%0d_ready", i), {15'b0, ready_o}, 16'd1);
        end
        pop();
        chk("stream_drained", {15'b0, v_o}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
